// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and modular helpers for the radix-2 NTT engine.
package ntt_pkg;
  localparam int DATA_W = 13;
  localparam int N      = 16;
  localparam int LOG_N  = $clog2(N);
  localparam int TW_W   = LOG_N - 1;
  localparam int STG_W  = $clog2(LOG_N) + 1;
  localparam int J_W    = LOG_N - 1;

  typedef logic [DATA_W-1:0] coef_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] k);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = k[LOG_N-1-i];
    return r;
  endfunction

  // Both operands are already reduced, so one conditional correction suffices.
  function automatic coef_t mod_add(input coef_t a, input coef_t b, input coef_t m);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[DATA_W-1:0];
  endfunction

  function automatic coef_t mod_sub(input coef_t a, input coef_t b, input coef_t m);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, m};
    return d[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/ntt_if.sv
// Sample/result stream and twiddle-ROM port of the NTT engine.
interface ntt_if;
  import ntt_pkg::*;

  // din is taken on a rising edge where valid && in_ready; ntt_o is meaningful
  // only while out_valid; there is no backpressure on the output side.
  coef_t              q;
  logic               valid;
  coef_t              din;
  logic               in_ready;
  logic [TW_W-1:0]    tw_addr;
  coef_t              tw_i;
  coef_t              ntt_o;
  logic               out_valid;
  logic               done;
  logic [STG_W-1:0]   stage;

  modport slave (
    input  q, valid, din, tw_i,
    output in_ready, tw_addr, ntt_o, out_valid, done, stage
  );

  modport master (
    output q, valid, din, tw_i,
    input  in_ready, tw_addr, ntt_o, out_valid, done, stage
  );
endinterface

// File: rtl/ntt_pe.sv
// Combinational Cooley-Tukey butterfly: a' = a + w*b, b' = a - w*b, all mod q.
module ntt_pe
  import ntt_pkg::*;
(
  input  coef_t a,
  input  coef_t b,
  input  coef_t w,
  input  coef_t q,
  output coef_t a_o,
  output coef_t b_o
);
  logic [2*DATA_W-1:0] prod;
  coef_t               t;

  always_comb begin
    prod = {{DATA_W{1'b0}}, w} * {{DATA_W{1'b0}}, b};
    t    = DATA_W'(prod % {{DATA_W{1'b0}}, q});
    a_o  = mod_add(a, t, q);
    b_o  = mod_sub(a, t, q);
  end
endmodule

// File: rtl/ntt_core.sv
// In-place radix-2 DIT NTT: bit-reversed load, log2(N) butterfly stages, natural-order output.
module ntt_core
  import ntt_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  ntt_if.slave   bus,
  output state_t dbg_state
);
  state_t           state_q, state_d;
  logic [LOG_N-1:0] cnt_q, cnt_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [STG_W-1:0] stage_q, stage_d;
  coef_t            mem_q [N];
  coef_t            mem_d [N];

  logic [LOG_N-1:0] j_ext, h, pos, i0, i1;
  coef_t            pe_a, pe_b;

  // Butterfly j of stage s pairs i0 with i0+h inside block j/h of width 2h.
  always_comb begin
    j_ext = {1'b0, j_q};
    h     = LOG_N'(1) << stage_q;
    pos   = j_ext & (h - LOG_N'(1));
    i0    = ((j_ext >> stage_q) << (stage_q + STG_W'(1))) | pos;
    i1    = i0 + h;
  end

  ntt_pe u_pe (
    .a   (mem_q[i0]),
    .b   (mem_q[i1]),
    .w   (bus.tw_i),
    .q   (bus.q),
    .a_o (pe_a),
    .b_o (pe_b)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    j_d           = j_q;
    stage_d       = stage_q;
    mem_d         = mem_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.done      = 1'b0;
    bus.ntt_o     = '0;
    bus.tw_addr   = '0;
    unique case (state_q)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.valid) begin
          mem_d[bitrev(cnt_q)] = bus.din;
          cnt_d = cnt_q + LOG_N'(1);
          if (cnt_q == LOG_N'(N - 1)) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        bus.tw_addr = TW_W'(pos << (STG_W'(TW_W) - stage_q));
        mem_d[i0]   = pe_a;
        mem_d[i1]   = pe_b;
        j_d         = j_q + J_W'(1);
        if (j_q == J_W'(N / 2 - 1)) begin
          if (stage_q == STG_W'(LOG_N - 1)) begin
            stage_d = '0;
            state_d = OUTPUT;
          end else begin
            stage_d = stage_q + STG_W'(1);
          end
        end
      end
      OUTPUT: begin
        bus.out_valid = 1'b1;
        bus.ntt_o     = mem_q[cnt_q];
        cnt_d         = cnt_q + LOG_N'(1);
        if (cnt_q == LOG_N'(N - 1)) begin
          bus.done = 1'b1;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      j_q     <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      stage_q <= stage_d;
    end
  end

  // Coefficient storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.stage = stage_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ntt_core.sv
// Bench for ntt_core: directed transforms plus random vectors against a direct-sum NTT model.
module tb_ntt_core;
  import ntt_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  coef_t  tw_tab [N/2];
  int     total;
  int     bad;
  coef_t  exp_q [$];
  coef_t  x_vec [N];
  int unsigned cur_q;
  int unsigned omega;

  coef_t pe_a, pe_b, pe_w, pe_q, pe_ao, pe_bo;

  ntt_if bus();
  assign bus.tw_i = tw_tab[bus.tw_addr];

  ntt_core dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  ntt_pe u_pe (
    .a   (pe_a),
    .b   (pe_b),
    .w   (pe_w),
    .q   (pe_q),
    .a_o (pe_ao),
    .b_o (pe_bo)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint unsigned pow_mod(input longint unsigned b, input longint unsigned e,
                                              input longint unsigned m);
    longint unsigned r;
    r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Primitive N-th root: w = g^((q-1)/N) with w^(N/2) = -1.
  function automatic int unsigned find_root(input int unsigned m);
    longint unsigned w;
    for (int unsigned g = 2; g < m; g++) begin
      w = pow_mod(g, (m - 1) / N, m);
      if (pow_mod(w, N / 2, m) == m - 1) return int'(w);
    end
    return 0;
  endfunction

  task automatic set_twiddles(input int unsigned m, input int unsigned w);
    for (int i = 0; i < N / 2; i++) tw_tab[i] = coef_t'(pow_mod(w, i, m));
  endtask

  // X[k] = sum_n x[n] * w^(n*k) mod q, pushed in natural order.
  task automatic push_golden(input int unsigned m, input int unsigned w);
    longint unsigned acc;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int n = 0; n < N; n++)
        acc = (acc + longint'(x_vec[n]) * pow_mod(w, (n * k) % N, m)) % m;
      exp_q.push_back(coef_t'(acc));
    end
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic rand_din();
    bus.din = coef_t'($urandom_range(0, cur_q - 1));
  endtask

  task automatic load_vec(input bit bursty, input bit hold);
    for (int n = 0; n < N; n++) begin
      if (bursty && n % 2 == 1) begin
        bus.valid = 1'b0;
        rand_din();
        @(negedge clk);
      end
      bus.valid = 1'b1;
      bus.din   = x_vec[n];
      @(negedge clk);
    end
    bus.valid = hold;
    rand_din();
  endtask

  task automatic run_transform(input bit bursty, input bit hold, input bit timing);
    int    k;
    coef_t e;
    load_vec(bursty, hold);
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 200) begin
      if (timing) begin
        check("stage_step", bus.stage, k / (N / 2));
        check("in_ready_busy", bus.in_ready, 0);
        if (k < N / 2) check("tw_addr_stage0", bus.tw_addr, 0);
      end
      if (hold) rand_din();
      @(negedge clk);
      k++;
    end
    check("out_valid_seen", k < 200, 1);
    if (timing) check("latency", k, (N / 2) * LOG_N);
    for (int o = 0; o < N; o++) begin
      e = exp_q.pop_front();
      check("out_valid", bus.out_valid, 1);
      check("ntt_o", bus.ntt_o, e);
      check("done", bus.done, o == N - 1);
      if (hold) rand_din();
      @(negedge clk);
    end
    bus.valid = 1'b0;
    check("out_valid_after", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
  endtask

  task automatic pe_case(input int unsigned a, input int unsigned b, input int unsigned w,
                         input int unsigned m);
    int unsigned t;
    pe_a = coef_t'(a);
    pe_b = coef_t'(b);
    pe_w = coef_t'(w);
    pe_q = coef_t'(m);
    #1;
    t = int'((longint'(w) * b) % m);
    check("pe_a_out", pe_ao, (a + t) % m);
    check("pe_b_out", pe_bo, (a + m - t) % m);
  endtask

  // ---------------- sequence ----------------
  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    bus.valid = 1'b0;
    bus.din   = '0;
    bus.q     = coef_t'(4801);
    cur_q     = 4801;
    for (int i = 0; i < N / 2; i++) tw_tab[i] = '0;

    // Butterfly element alone.
    pe_case(3313, 1108, 990, 4801);
    check("pe_known_a", pe_ao, 804);
    check("pe_known_b", pe_bo, 1021);
    for (int i = 0; i < 8; i++)
      pe_case($urandom_range(0, 4800), $urandom_range(0, 4800), $urandom_range(0, 4800), 4801);
    pe_case(0, 4800, 4800, 4801);
    pe_case(4800, 4800, 4800, 4801);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_ntt_o", bus.ntt_o, 0);
    check("rst_tw_addr", bus.tw_addr, 0);
    check("rst_stage", bus.stage, 0);
    reset = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_state", dbg_state, LOAD);

    // Delta input with an arbitrary twiddle table.
    for (int i = 0; i < N / 2; i++) tw_tab[i] = coef_t'($urandom_range(0, 4800));
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'(n == 0);
    for (int k = 0; k < N; k++) exp_q.push_back(coef_t'(1));
    run_transform(1'b0, 1'b0, 1'b0);

    // Constant input with real twiddles; also exercises latency/stage/tw_addr timing.
    omega = find_root(4801);
    check("root_found", omega != 0, 1);
    set_twiddles(4801, omega);
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'(5);
    exp_q.push_back(coef_t'(80));
    for (int k = 1; k < N; k++) exp_q.push_back(coef_t'(0));
    run_transform(1'b0, 1'b0, 1'b1);

    // Random vector gapless, then the same vector bursty with valid held high.
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'($urandom_range(0, 4800));
    push_golden(4801, omega);
    run_transform(1'b0, 1'b0, 1'b1);
    push_golden(4801, omega);
    run_transform(1'b1, 1'b1, 1'b1);

    // Different modulus, including extreme coefficient values.
    cur_q = 7681;
    bus.q = coef_t'(7681);
    omega = find_root(7681);
    set_twiddles(7681, omega);
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'($urandom_range(0, 7680));
    x_vec[1] = coef_t'(7680);
    x_vec[2] = coef_t'(0);
    push_golden(7681, omega);
    run_transform(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'(7680);
    push_golden(7681, omega);
    run_transform(1'b1, 1'b0, 1'b0);

    // Reset in the middle of COMPUTE, then a fresh delta transform.
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'($urandom_range(0, 7680));
    load_vec(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("mid_stage", bus.stage, 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_stage", bus.stage, 0);
    check("abort_in_ready", bus.in_ready, 1);
    reset = 1'b1;
    for (int n = 0; n < N; n++) x_vec[n] = coef_t'(n == 0);
    for (int k = 0; k < N; k++) exp_q.push_back(coef_t'(1));
    run_transform(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
